// File: rtl/button_scheduler.sv
// button_scheduler: debounces NBTN active-low pushbuttons with one shared counter and queues press/release events
// Ports: clk, rst_n (sync, active-low); btn_n raw buttons (active-low, async);
//        ev_valid/ev_ready/ev_code/ev_release event FIFO head handshake;
//        btn_state debounced levels (1 = held); busy shared counter owned; ev_drop event lost on full FIFO.
// Build option: BUTTON_SCHEDULER_RELEASE_EV_EN also queues release events (ev_release = 1).
module button_scheduler #(
    parameter int NBTN  = 5,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn_n,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [2:0]      ev_code,
    output logic            ev_release,
    output logic [NBTN-1:0] btn_state,
    output logic            busy,
    output logic            ev_drop
);
    localparam int IW = $clog2(NBTN);
    typedef enum logic {SCAN, TRACK} state_t;
    state_t           state, state_n;
    logic [NBTN-1:0]  s1, sync, mism;
    logic [IW-1:0]    rr, rr_n, owner, owner_n, owner_inc, pick, idx;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             hit, commit, push, pop, full, push_ok;
    logic [2:0]       code_mem [4];
    logic [1:0]       wp, rp;
    logic [2:0]       count;
`ifdef BUTTON_SCHEDULER_RELEASE_EV_EN
    localparam bit REL_EN = 1'b1;
    logic rel_mem [4];
    assign ev_release = ev_valid & rel_mem[rp];
`else
    localparam bit REL_EN = 1'b0;
    assign ev_release = 1'b0;
`endif
    assign mism      = sync ^ btn_state;
    assign owner_inc = (owner == IW'(NBTN - 1)) ? '0 : owner + 1'b1;
    assign busy      = (state == TRACK);
    assign ev_valid  = (count != 3'd0);
    assign ev_code   = ev_valid ? code_mem[rp] : 3'd0;
    assign full      = count[2];
    assign pop       = ev_valid & ev_ready;
    // Press commits always queue; release commits only when release events are enabled.
    assign push      = commit & (~btn_state[owner] | REL_EN);
    assign push_ok   = push & (~full | pop);
    // Round-robin search for the first mismatched button starting at rr.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        idx  = '0;
        for (int k = 0; k < NBTN; k++) begin
            idx = IW'((int'(rr) + k) % NBTN);
            if (!hit && mism[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end
    always_comb begin
        state_n = state;
        owner_n = owner;
        rr_n    = rr;
        cnt_n   = cnt;
        commit  = 1'b0;
        if (state == SCAN) begin
            if (hit) begin
                state_n = TRACK;
                owner_n = pick;
                cnt_n   = '0;
            end
        end else if (!mism[owner] || &cnt) begin
            // Abandon (input settled back) or commit (stable for 2^CNT_W cycles); both release ownership.
            state_n = SCAN;
            rr_n    = owner_inc;
            commit  = mism[owner];
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SCAN;
            owner <= '0;
            rr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            rr    <= rr_n;
            cnt   <= cnt_n;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= '0;
            sync      <= '0;
            btn_state <= '0;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            ev_drop   <= 1'b0;
        end else begin
            s1   <= ~btn_n;
            sync <= s1;
            if (commit) btn_state[owner] <= ~btn_state[owner];
            if (push_ok) begin
                code_mem[wp] <= 3'(owner);
`ifdef BUTTON_SCHEDULER_RELEASE_EV_EN
                rel_mem[wp]  <= btn_state[owner];
`endif
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count   <= count + 3'(push_ok) - 3'(pop);
            ev_drop <= push & full & ~pop;
        end
    end
endmodule

// File: tb/tb_button_scheduler.sv
// tb_button_scheduler: directed checks of button_scheduler with CNT_W=4
module tb_button_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ev_ready = 1'b0;
    logic [4:0] btn_n = '1;
    logic       ev_valid, ev_release, busy, ev_drop, busy_q;
    logic [2:0] ev_code;
    logic [4:0] btn_state;
    int         checks = 0;
    int         errors = 0;
    int         drops, rises;

    always #5 clk = ~clk;

    button_scheduler #(.NBTN(5), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_release(ev_release), .btn_state(btn_state), .busy(busy), .ev_drop(ev_drop)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_n = '1;
        ev_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        tick(3);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_code", 32'(ev_code), 0);
        chk("rst_rel", 32'(ev_release), 0);
        chk("rst_state", 32'(btn_state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(ev_drop), 0);
        rst_n = 1'b1;
        // single clean press of button 2
        btn_n = 5'b11011;
        tick(2);
        chk("p2_sync_busy", 32'(busy), 0);
        tick(1);
        chk("p2_track_busy", 32'(busy), 1);
        tick(15);
        chk("p2_early_valid", 32'(ev_valid), 0);
        tick(1);
        chk("p2_valid", 32'(ev_valid), 1);
        chk("p2_code", 32'(ev_code), 2);
        chk("p2_rel", 32'(ev_release), 0);
        chk("p2_state", 32'(btn_state), 4);
        chk("p2_busy_done", 32'(busy), 0);
        tick(20);
        chk("p2_held_valid", 32'(ev_valid), 1);
        ev_ready = 1'b1;
        tick(1);
        chk("p2_pop", 32'(ev_valid), 0);
        tick(1);
        ev_ready = 1'b0;
        chk("p2_pop_empty", 32'(ev_valid), 0);
        chk("p2_state_kept", 32'(btn_state), 4);
        // bouncing button 0 never commits
        do_reset();
        rises = 0;
        busy_q = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn_n[0] = ~btn_n[0];
            for (int c = 0; c < 5; c++) begin
                tick(1);
                if (busy && !busy_q) rises++;
                busy_q = busy;
            end
        end
        tick(25);
        chk("bounce_busy_pulses", 32'(rises >= 3), 1);
        chk("bounce_state", 32'(btn_state), 0);
        chk("bounce_valid", 32'(ev_valid), 0);
        // simultaneous presses of 1 and 3 with rr=0
        do_reset();
        btn_n = 5'b10101;
        tick(19);
        chk("rr_first_valid", 32'(ev_valid), 1);
        chk("rr_first_code", 32'(ev_code), 1);
        chk("rr_first_state", 32'(btn_state), 2);
        tick(17);
        chk("rr_head_kept", 32'(ev_code), 1);
        chk("rr_both_state", 32'(btn_state), 10);
        ev_ready = 1'b1;
        tick(1);
        chk("rr_second_valid", 32'(ev_valid), 1);
        chk("rr_second_code", 32'(ev_code), 3);
        tick(1);
        ev_ready = 1'b0;
        chk("rr_drained", 32'(ev_valid), 0);
        // five presses into a 4-deep FIFO: fifth is dropped
        do_reset();
        btn_n = '0;
        drops = 0;
        repeat (88) begin
            tick(1);
            if (ev_drop) drops++;
        end
        chk("full_drop_count", 32'(drops), 1);
        chk("full_state", 32'(btn_state), 31);
        for (int i = 0; i < 4; i++) begin
            chk("full_valid", 32'(ev_valid), 1);
            chk("full_code", 32'(ev_code), 32'(i));
            ev_ready = 1'b1;
            tick(1);
            ev_ready = 1'b0;
        end
        chk("full_drained", 32'(ev_valid), 0);
        // same, but pop on the fifth commit cycle: no drop
        do_reset();
        btn_n = '0;
        drops = 0;
        repeat (86) begin
            tick(1);
            if (ev_drop) drops++;
        end
        ev_ready = 1'b1;
        tick(1);
        if (ev_drop) drops++;
        ev_ready = 1'b0;
        tick(1);
        if (ev_drop) drops++;
        chk("pushpop_drop_count", 32'(drops), 0);
        chk("pushpop_state", 32'(btn_state), 31);
        for (int i = 1; i < 5; i++) begin
            chk("pushpop_valid", 32'(ev_valid), 1);
            chk("pushpop_code", 32'(ev_code), 32'(i));
            ev_ready = 1'b1;
            tick(1);
            ev_ready = 1'b0;
        end
        chk("pushpop_drained", 32'(ev_valid), 0);
        // reset mid-TRACK with a queued event
        do_reset();
        btn_n = 5'b10101;
        tick(29);
        chk("midrst_busy_before", 32'(busy), 1);
        chk("midrst_valid_before", 32'(ev_valid), 1);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(ev_valid), 0);
        chk("midrst_state", 32'(btn_state), 0);
        chk("midrst_code", 32'(ev_code), 0);
        rst_n = 1'b1;
        tick(18);
        chk("midrst_fresh_early", 32'(ev_valid), 0);
        tick(1);
        chk("midrst_fresh_valid", 32'(ev_valid), 1);
        chk("midrst_fresh_code", 32'(ev_code), 1);
        // press then release button 4
        do_reset();
        btn_n = 5'b01111;
        tick(19);
        chk("b4_press_valid", 32'(ev_valid), 1);
        chk("b4_press_code", 32'(ev_code), 4);
        chk("b4_press_rel", 32'(ev_release), 0);
        chk("b4_press_state", 32'(btn_state), 16);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        chk("b4_press_pop", 32'(ev_valid), 0);
        btn_n = '1;
        tick(19);
        chk("b4_rel_state", 32'(btn_state), 0);
`ifdef BUTTON_SCHEDULER_RELEASE_EV_EN
        chk("b4_rel_valid", 32'(ev_valid), 1);
        chk("b4_rel_code", 32'(ev_code), 4);
        chk("b4_rel_rel", 32'(ev_release), 1);
`else
        chk("b4_rel_valid", 32'(ev_valid), 0);
        chk("b4_rel_rel", 32'(ev_release), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
